// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM states and fault cause codes for the load/store stage
package lsu_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam logic [1:0] C_NONE     = 2'b00;
  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_ILLEGAL  = 2'b10;
  localparam logic [1:0] C_TIMEOUT  = 2'b11;
endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: data-memory req/ack bus
//   master (LSU): drives bus_req, bus_we, bus_addr, bus_wdata, bus_be; samples bus_rdata, bus_ack
//   slave (memory): the reverse
interface lsu_mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be, input bus_rdata, bus_ack);
  modport slave  (input bus_req, bus_we, bus_addr, bus_wdata, bus_be, output bus_rdata, bus_ack);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction plus sign/zero extension for loads
//   store path: i_st_ofs, i_st_sz (funct3[1:0]), i_wdata -> o_be, o_wdata
//   load path:  i_ld_ofs, i_ld_f3, i_rdata -> o_ldata
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  i_st_ofs,
  input  logic [1:0]  i_st_sz,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_ofs,
  input  logic [2:0]  i_ld_f3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sgn;
  always_comb begin
    o_be    = i_st_sz == F3_SB[1:0] ? 4'b0001 << i_st_ofs : i_st_sz == F3_SH[1:0] ? 4'b0011 << i_st_ofs : 4'b1111;
    // Data is replicated into every lane; bus_be selects which lanes land.
    o_wdata = i_st_sz == F3_SB[1:0] ? {4{i_wdata[7:0]}} : i_st_sz == F3_SH[1:0] ? {2{i_wdata[15:0]}} : i_wdata;
    w_byte  = 8'(i_rdata >> {i_ld_ofs, 3'b000});
    w_half  = i_ld_ofs[1] ? i_rdata[31:16] : i_rdata[15:0];
    // funct3[2] marks the unsigned variants (LBU/LHU).
    w_sgn   = ~i_ld_f3[2];
    o_ldata = i_ld_f3[1:0] == F3_LB[1:0] ? {{24{w_sgn & w_byte[7]}}, w_byte} :
              i_ld_f3[1:0] == F3_LH[1:0] ? {{16{w_sgn & w_half[15]}}, w_half} : i_rdata;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage turning one core access into one req/ack bus transaction
//   core side: addr, wdata, funct3, mem_rd, mem_wr in; stall, rdata, fault, fault_cause out
//   bus side:  lsu_mem_stage_if.master (req/we/addr/wdata/be out, rdata/ack in)
//   TIMEOUT: max BUSY cycles without bus_ack before a timeout fault (0 disables)
module lsu_mem_stage import lsu_pkg::*; #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  lsu_mem_stage_if.master bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t      r_state, w_next;
  logic [29:0] r_waddr;
  logic [1:0]  r_ofs;
  logic [2:0]  r_f3;
  logic        r_we, r_to;
  logic [3:0]  r_be;
  logic [31:0] r_wdata, r_rdata;
  logic [CW-1:0] r_cnt;
  logic        w_ill, w_mis, w_start, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldata;
  lsu_align u_align (
    .i_st_ofs(addr[1:0]), .i_st_sz(funct3[1:0]), .i_wdata(wdata), .o_be(w_be), .o_wdata(w_wdata),
    .i_ld_ofs(r_ofs), .i_ld_f3(r_f3), .i_rdata(bus.bus_rdata), .o_ldata(w_ldata)
  );
  assign bus.bus_req   = r_state == S_BUSY;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_waddr, 2'b00};
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_be    = r_be;
  assign rdata         = r_state == S_DONE ? r_rdata : '0;
  always_comb begin
    w_ill       = mem_wr ? (funct3[2] | funct3[1:0] == 2'b11) : (funct3 == 3'b011 | funct3[2:1] == 2'b11);
    w_mis       = (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & addr[1:0] != 2'b00);
    w_tmo       = TIMEOUT > 0 && r_cnt == CW'(TIMEOUT - 1);
    w_start     = 1'b0;
    w_next      = r_state;
    stall       = 1'b0;
    fault       = 1'b0;
    fault_cause = C_NONE;
    case (r_state)
      // rst_n gating keeps the combinational IDLE outputs at 0 while reset is held.
      S_IDLE: if ((mem_rd | mem_wr) & rst_n) begin
        fault       = w_ill | w_mis;
        fault_cause = w_ill ? C_ILLEGAL : w_mis ? C_MISALIGN : C_NONE;
        w_start     = ~fault;
        stall       = w_start;
        w_next      = w_start ? S_BUSY : S_IDLE;
      end
      S_BUSY: begin
        stall  = 1'b1;
        w_next = bus.bus_ack | w_tmo ? S_DONE : S_BUSY;
      end
      S_DONE: begin
        fault       = r_to;
        fault_cause = r_to ? C_TIMEOUT : C_NONE;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_ofs   <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_to    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_waddr <= addr[31:2];
        r_ofs   <= addr[1:0];
        r_f3    <= funct3;
        r_we    <= mem_wr;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_cnt   <= '0;
        r_to    <= 1'b0;
      end else if (r_state == S_BUSY) begin
        // An ack on the timeout cycle completes normally.
        if (bus.bus_ack) begin
          if (!r_we) r_rdata <= w_ldata;
        end else if (w_tmo) begin
          r_rdata <= '0;
          r_to    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized scoreboard bench for lsu_mem_stage with a reference model and memory responder
module tb_lsu_mem_stage;
  import lsu_pkg::*;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic        stall, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        stray_all = 1'b0;
  lsu_mem_stage_if bus();
  lsu_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .funct3(funct3),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .stall(stall), .rdata(rdata),
    .fault(fault), .fault_cause(fault_cause), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] waddr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    bit          noack;
    bit          abort;
    logic [31:0] data;
  } plan_t;
  typedef struct {
    logic [1:0]  cause;
    logic [31:0] rdata;
  } rsp_t;
  plan_t plan_q[$];
  rsp_t  exp_q[$];
  int checks = 0, errors = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] ofs, input logic [31:0] d);
    int sz = size_of(f3);
    logic [31:0] m = sz == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
    logic [31:0] v = (d >> (8 * int'(ofs))) & m;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int delay, input bit noack, input logic [31:0] d);
    int sz = size_of(f3);
    bit ill, mis;
    int exp_n = 0, n = 0;
    rsp_t r;
    plan_t p;
    ill = wr ? (f3[2] || f3 == 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = !ill && (a % 32'(sz)) != 0;
    if (rd || wr) begin
      if (ill || mis) begin
        r.cause = ill ? 2'b10 : 2'b01;
        r.rdata = '0;
        exp_q.push_back(r);
      end else begin
        p.waddr = a & ~32'h3;
        p.we    = wr;
        p.be    = '0;
        p.wdata = '0;
        for (int i = 0; i < 4; i++) begin
          p.be[i] = i >= int'(a[1:0]) && i < int'(a[1:0]) + sz;
          p.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        p.delay = delay;
        p.noack = noack;
        p.abort = 1'b0;
        p.data  = d;
        plan_q.push_back(p);
        if (noack) last_rd = '0;
        else if (!wr) last_rd = load_val(f3, a[1:0], d);
        r.cause = noack ? 2'b11 : 2'b00;
        r.rdata = last_rd;
        exp_q.push_back(r);
        exp_n = 1 + (noack ? TO : delay + 1);
      end
    end
    addr = a; wdata = wd; funct3 = f3; mem_rd = rd; mem_wr = wr;
    @(negedge clk);
    while (stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), 32'(exp_n));
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // Memory responder: serves transactions from the plan queue, pulses stray acks when idle.
  initial begin
    plan_t p;
    int k;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.bus_req !== 1'b1) begin
        bus.bus_ack = stray_all || $urandom_range(0, 3) == 0;
        bus.bus_rdata = $urandom;
      end else if (plan_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got addr %h with no pending access", bus.bus_addr);
        bus.bus_ack = 1'b1;
      end else begin
        p = plan_q.pop_front();
        bus.bus_ack = 1'b0;
        chk("bus_addr", bus.bus_addr, p.waddr);
        chk("bus_we", 32'(bus.bus_we), 32'(p.we));
        chk("bus_be", 32'(bus.bus_be), 32'(p.be));
        if (p.we) chk("bus_wdata", bus.bus_wdata & {{8{p.be[3]}}, {8{p.be[2]}}, {8{p.be[1]}}, {8{p.be[0]}}},
                      p.wdata & {{8{p.be[3]}}, {8{p.be[2]}}, {8{p.be[1]}}, {8{p.be[0]}}});
        if (p.noack) begin
          k = 1;
          while (bus.bus_req === 1'b1 && k < 50) begin
            @(negedge clk);
            if (bus.bus_req === 1'b1) k++;
          end
          if (!p.abort) chk("req_cycles", 32'(k), 32'(TO));
        end else begin
          repeat (p.delay) begin
            @(negedge clk);
            chk("req_held", {31'b0, bus.bus_req}, {31'b0, 1'b1});
            chk("addr_held", bus.bus_addr, p.waddr);
          end
          bus.bus_rdata = p.data;
          bus.bus_ack = 1'b1;
        end
      end
    end
  end

  // Monitor: a response is a fault pulse or the first non-stalled cycle after a stall.
  initial begin
    logic ps;
    rsp_t e;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) ps = 1'b0;
      else begin
        if (fault || (ps && !stall)) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got fault %b cause %b rdata %h with nothing expected", fault, fault_cause, rdata);
          end else begin
            e = exp_q.pop_front();
            chk("fault", 32'(fault), 32'(e.cause != 2'b00));
            chk("fault_cause", 32'(fault_cause), 32'(e.cause));
            chk("rdata", rdata, e.rdata);
          end
        end else begin
          chk("idle_rdata", rdata, 32'h0);
          chk("idle_cause", 32'(fault_cause), 32'h0);
        end
        ps = stall;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p;
    logic rd, wr;
    #12;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_cause", 32'(fault_cause), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", 32'(bus.bus_req), 32'h0);
    chk("rst_we", 32'(bus.bus_we), 32'h0);
    chk("rst_addr", bus.bus_addr, 32'h0);
    chk("rst_wdata", bus.bus_wdata, 32'h0);
    chk("rst_be", 32'(bus.bus_be), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 0, F3_LW,  32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    issue(1, 0, F3_LB,  32'h103, 32'h0, 1, 0, 32'h80112233);
    issue(1, 0, F3_LBU, 32'h103, 32'h0, 2, 0, 32'h80112233);
    issue(1, 0, F3_LHU, 32'h102, 32'h0, 0, 0, 32'h80112233);
    issue(1, 0, F3_LH,  32'h102, 32'h0, 0, 0, 32'h80112233);
    issue(0, 1, F3_SH,  32'h202, 32'h0000ABCD, 0, 0, 32'h0);
    issue(1, 0, F3_LW,  32'h101, 32'h0, 0, 0, 32'h0);
    issue(0, 1, 3'b110, 32'h200, 32'h0, 0, 0, 32'h0);
    issue(1, 0, 3'b111, 32'h201, 32'h0, 0, 0, 32'h0);
    issue(1, 0, F3_LW,  32'h040, 32'h0, 0, 1, 32'h0);
    issue(1, 0, F3_LW,  32'h044, 32'h0, TO - 1, 0, 32'h12345678);
    issue(1, 1, F3_SB,  32'h301, 32'h000000A5, 1, 0, 32'h0);
    for (int t = 0; t < 300; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      issue(rd, wr, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF, $urandom,
            $urandom_range(0, TO - 1), $urandom_range(0, 7) == 0, $urandom);
    end
    p.waddr = 32'h500; p.we = 1'b0; p.be = 4'hF; p.wdata = '0;
    p.delay = 0; p.noack = 1'b1; p.abort = 1'b1; p.data = '0;
    plan_q.push_back(p);
    addr = 32'h500; funct3 = F3_LW; mem_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus.bus_req), 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    last_rd = '0;
    @(posedge clk);
    #1;
    mem_rd = 1'b0;
    stray_all = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_req", 32'(bus.bus_req), 32'h0);
      chk("post_rst_stall", 32'(stall), 32'h0);
    end
    stray_all = 1'b0;
    @(posedge clk);
    #1;
    issue(1, 0, F3_LHU, 32'h602, 32'h0, 1, 0, 32'hFEDC1234);
    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("plan_q_drained", 32'(plan_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly downstream of the core ALU: ALU result is the effective address; rs2 is the store data.
- Converts a load/store into a single req/ack transaction on the data-memory bus, with byte-lane steering and load sign/zero extension.
- Stalls the single-cycle core while the bus is busy; reports misaligned, illegal-width and bus-timeout faults.

Parameters:
- TIMEOUT, 255: max cycles in BUSY waiting for bus_ack; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  32  effective address (ALU out)
- wdata  in  32  store data (rs2)
- funct3  in  3  access width/sign, RISC-V encoding
- mem_rd  in  1  load request
- mem_wr  in  1  store request
- stall  out  1  hold PC/writeback
- rdata  out  32  extended load result, valid in DONE
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  01 misaligned, 10 illegal width, 11 bus timeout; 00 when fault=0
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address (addr[1:0] forced 00)
- bus_wdata  out  32  lane-steered store data
- bus_be  out  4  byte enables
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transaction complete

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset forces state IDLE and clears the timeout counter and rdata register.
- Output values in reset: all outputs 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access = mem_rd | mem_wr:
  - mem_wr has priority if both are high.
  - Illegal width (fault, cause 10, stall=0, no bus access, stay IDLE): funct3 011, 110 or 111; stores with funct3[2]=1.
  - Misaligned (fault, cause 01, stall=0, no bus access, stay IDLE): halfword with addr[0]=1; word with addr[1:0]!=00. Illegal width takes precedence over misaligned.
  - Legal access: stall=1 combinationally in this cycle. Latch word address, bus_be, steered wdata, we, funct3 and addr[1:0]. Clear the counter. Go to BUSY.
- BUSY:
  - bus_req=1 and stall=1. Bus outputs come from latched registers and are stable until ack.
  - On bus_ack: capture the extracted and extended bus_rdata (loads) into the rdata register, then go to DONE.
  - If no ack and counter==TIMEOUT-1 (TIMEOUT>0): rdata register=0, go to DONE with timeout flagged. Otherwise the counter increments.
  - ack in the same cycle as the timeout: ack wins, no fault.
- DONE:
  - stall=0 and rdata valid; the core commits at this edge.
  - A timeout gives fault=1, cause 11.
  - Always return to IDLE. mem_rd/mem_wr still high this cycle does not reissue.
- Byte enables: SB gives 0001<<addr[1:0]. SH gives 0011<<addr[1:0]. SW gives 1111. Store data is replicated into the selected lanes.
- Load extraction: LB/LBU select the byte at addr[1:0]; LH/LHU select the half at addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores leave the rdata register unchanged. rdata reads 0 outside DONE.
- Other rules:
  - bus_ack outside BUSY is ignored.
  - Reset mid-BUSY drops bus_req immediately (asynchronous).
  - Zero-wait ack gives 3 cycles per access: stall high 2 cycles, then DONE.

Decomposition:
- Shared package lsu_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), the FSM state enum, and the fault cause codes.
- One combinational sub-module, lsu_align:
  - Store path: addr[1:0], funct3, wdata -> bus_be and bus_wdata.
  - Load path: addr[1:0], funct3, bus_rdata -> extended load data.

Test Plan:
- LW addr=0x100, bus_rdata=0xDEADBEEF, ack in first BUSY cycle -> bus_addr=0x100, bus_be=1111, stall high 2 cycles, DONE rdata=0xDEADBEEF.
- LB addr=0x103 with 0x80112233 -> rdata=0xFFFFFF80. LBU addr=0x103 -> 0x00000080. LHU addr=0x102 -> 0x00008011.
- SH addr=0x202, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata[31:16]=0xABCD, bus_addr=0x200.
- LW addr=0x101 -> fault=1 and cause=01 for one cycle, stall=0, bus_req never asserted. SW with funct3=110 -> cause 10.
- TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then DONE with fault cause 11 and rdata=0. A repeat with ack on the 4th cycle -> no fault.
- rst_n low mid-BUSY -> bus_req and stall drop without a clock edge. After release the FSM is in IDLE, and a stray bus_ack is ignored.
